// File: rtl/fmap_pingpong_buf_pkg.sv
// Shared constants and bank-ring pointer arithmetic for the fmap ping-pong buffer.
package fmap_pingpong_buf_pkg;

  localparam int FMAP_DATA_W = 64;
  localparam int FMAP_ADDR_W = 12;

  // Explicit wrap so bank counts that are not a power of 2 ring correctly.
  function automatic int bank_ptr_inc(input int ptr, input int n_bank);
    return (ptr == n_bank - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// One feature-map bank: simple dual-port RAM with a registered read and RD_LAT-1 extra output stages.
module pp_bank_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [RD_LAT-1:0] ld,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0]              mem [0:2**ADDR_W-1];
  logic [RD_LAT-1:0][DATA_W-1:0] stg_q;

  // Stages load only for reads that target this bank, so the last stage holds between reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld[0]) stg_q[0] <= mem[rd_addr];
    for (int k = 1; k < RD_LAT; k++)
      if (ld[k]) stg_q[k] <= stg_q[k-1];
  end

  assign rd_data = stg_q[RD_LAT-1];

endmodule

// File: rtl/fmap_pingpong_buf.sv
// N-bank ping-pong feature-map buffer: producer fills one bank while the consumer drains a committed one.
module fmap_pingpong_buf
  import fmap_pingpong_buf_pkg::*;
#(
  parameter int DATA_W = FMAP_DATA_W,
  parameter int ADDR_W = FMAP_ADDR_W,
  parameter int N_BANK = 2,
  parameter int RD_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         wr_last,
  output logic                         rd_avail,
  input  logic                         rd_req,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_valid,
  output logic [DATA_W-1:0]            rd_data,
  input  logic                         rd_release,
  output logic [$clog2(N_BANK+1)-1:0]  fill_cnt,
  output logic [1:0]                   err
);

  localparam int PTR_W = $clog2(N_BANK);
  localparam int CNT_W = $clog2(N_BANK+1);

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};

  assign rst_int_n = rst_sync_q[1];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic             wr_ready_q, wr_ready_d, rd_avail_q, rd_avail_d;
  logic [1:0]       err_q, err_d;
  logic             seen_q, seen_d;
  logic [RD_LAT:1]  vld_q, vld_d;
  logic [RD_LAT:1][PTR_W-1:0] sel_q, sel_d;
  logic [RD_LAT:0]            vld_pipe;
  logic [RD_LAT:0][PTR_W-1:0] sel_pipe;
  logic wr_acc, commit, rd_acc, rel;
  logic [N_BANK-1:0][DATA_W-1:0] bank_q;

  assign wr_acc = wr_valid & wr_ready_q;
  assign commit = wr_acc & wr_last;
  assign rd_acc = rd_req & rd_avail_q;
  assign rel    = rd_release & rd_avail_q;

  always_comb begin
    wr_ptr_d   = commit ? PTR_W'(bank_ptr_inc(int'(wr_ptr_q), N_BANK)) : wr_ptr_q;
    rd_ptr_d   = rel    ? PTR_W'(bank_ptr_inc(int'(rd_ptr_q), N_BANK)) : rd_ptr_q;
    fill_cnt_d = fill_cnt_q;
    case ({commit, rel})
      2'b10:   fill_cnt_d = fill_cnt_q + CNT_W'(1);
      2'b01:   fill_cnt_d = fill_cnt_q - CNT_W'(1);
      default: fill_cnt_d = fill_cnt_q;
    endcase
    wr_ready_d = fill_cnt_d < CNT_W'(N_BANK);
    rd_avail_d = fill_cnt_d != '0;
    err_d      = err_q | {(rd_req | rd_release) & ~rd_avail_q, wr_valid & ~wr_ready_q};
    // Stage 0 is the acceptance cycle; the bank index is frozen there so a same-cycle release reads the old bank.
    vld_pipe    = {vld_q, rd_acc};
    sel_pipe[0] = rd_ptr_q;
    for (int k = 1; k <= RD_LAT; k++) sel_pipe[k] = sel_q[k];
    vld_d = vld_pipe[RD_LAT-1:0];
    for (int k = 1; k <= RD_LAT; k++)
      sel_d[k] = vld_pipe[k-1] ? sel_pipe[k-1] : sel_q[k];
    seen_d = seen_q | vld_pipe[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_cnt_q <= '0;
      wr_ready_q <= 1'b1;
      rd_avail_q <= 1'b0;
      err_q      <= '0;
      seen_q     <= 1'b0;
      vld_q      <= '0;
      sel_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      wr_ready_q <= wr_ready_d;
      rd_avail_q <= rd_avail_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      vld_q      <= vld_d;
      sel_q      <= sel_d;
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_bank
    logic [RD_LAT-1:0] ld;
    always_comb
      for (int k = 0; k < RD_LAT; k++)
        ld[k] = vld_pipe[k] && (sel_pipe[k] == PTR_W'(b));

    pp_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_ram (
      .clk     (clk),
      .wr_en   (wr_acc && (wr_ptr_q == PTR_W'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .ld      (ld),
      .rd_data (bank_q[b])
    );
  end

  assign wr_ready = wr_ready_q;
  assign rd_avail = rd_avail_q;
  assign rd_valid = vld_q[RD_LAT];
  assign rd_data  = seen_q ? bank_q[sel_q[RD_LAT]] : '0;
  assign fill_cnt = fill_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fmap_pingpong_buf.sv
// Directed bench: instance 0 is N_BANK=2/RD_LAT=1, instance 1 is N_BANK=3/RD_LAT=2.
module tb_fmap_pingpong_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wv [2], wl [2], rq [2], rl [2];
  logic [11:0] wa [2], ra [2];
  logic [63:0] wd [2];
  logic        wrdy [2], ravl [2], rvld [2];
  logic [63:0] rdat [2];
  logic [1:0]  fcnt [2], err [2];

  int n_chk = 0;
  int n_pass = 0;

  fmap_pingpong_buf #(.N_BANK(2), .RD_LAT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[0]), .wr_ready(wrdy[0]), .wr_addr(wa[0]),
    .wr_data(wd[0]), .wr_last(wl[0]), .rd_avail(ravl[0]), .rd_req(rq[0]), .rd_addr(ra[0]),
    .rd_valid(rvld[0]), .rd_data(rdat[0]), .rd_release(rl[0]), .fill_cnt(fcnt[0]), .err(err[0])
  );

  fmap_pingpong_buf #(.N_BANK(3), .RD_LAT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv[1]), .wr_ready(wrdy[1]), .wr_addr(wa[1]),
    .wr_data(wd[1]), .wr_last(wl[1]), .rd_avail(ravl[1]), .rd_req(rq[1]), .rd_addr(ra[1]),
    .rd_valid(rvld[1]), .rd_data(rdat[1]), .rd_release(rl[1]), .fill_cnt(fcnt[1]), .err(err[1])
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [11:0] a, input logic [63:0] v, input logic last);
    wv[d] = 1'b1; wa[d] = a; wd[d] = v; wl[d] = last;
    step();
    wv[d] = 1'b0; wl[d] = 1'b0;
  endtask

  task automatic release_bank(input int d);
    rl[d] = 1'b1;
    step();
    rl[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [11:0] a, input logic [63:0] exp, input logic rel,
                    input int lat, input string tag);
    rq[d] = 1'b1; ra[d] = a; rl[d] = rel;
    step();
    rq[d] = 1'b0; rl[d] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk({tag, "_early"}, 64'(rvld[d]), 64'd0);
      step();
    end
    chk({tag, "_vld"}, 64'(rvld[d]), 64'd1);
    chk(tag, rdat[d], exp);
  endtask

  function automatic logic [63:0] pat(input int r, input int i);
    logic [7:0] b;
    b = 8'(r * 16 + i);
    return {8{b}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      wv[d] = 0; wl[d] = 0; rq[d] = 0; rl[d] = 0; wa[d] = 0; ra[d] = 0; wd[d] = 0;
    end
    step(); step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_wr_ready", 64'(wrdy[d]), 64'd1);
      chk("rst_rd_avail", 64'(ravl[d]), 64'd0);
      chk("rst_rd_valid", 64'(rvld[d]), 64'd0);
      chk("rst_rd_data",  rdat[d], 64'd0);
      chk("rst_fill_cnt", 64'(fcnt[d]), 64'd0);
      chk("rst_err",      64'(err[d]), 64'd0);
    end
    rst_n = 1'b1;
    step(); step(); step();

    // 1: fill and drain one bank
    for (int i = 0; i < 4; i++) wr(0, 12'(i), 64'hA0 + 64'(i), i == 3);
    chk("t1_fill", 64'(fcnt[0]), 64'd1);
    chk("t1_avail", 64'(ravl[0]), 64'd1);
    for (int i = 0; i < 4; i++) rd(0, 12'(i), 64'hA0 + 64'(i), 1'b0, 1, "t1_rd");
    step();
    chk("t1_vld_pulse", 64'(rvld[0]), 64'd0);
    chk("t1_hold", rdat[0], 64'hA3);

    // 2: full ring blocks writes
    wr(0, 12'd0, 64'hB0, 1'b0);
    wr(0, 12'd5, 64'hB5, 1'b1);
    chk("t2_fill", 64'(fcnt[0]), 64'd2);
    chk("t2_full", 64'(wrdy[0]), 64'd0);
    wr(0, 12'd0, 64'hDEAD, 1'b1);
    chk("t2_err0", 64'(err[0]), 64'd1);
    chk("t2_fill_keep", 64'(fcnt[0]), 64'd2);
    rd(0, 12'd0, 64'hA0, 1'b0, 1, "t2_bank0_kept");
    release_bank(0);
    chk("t2_ready_back", 64'(wrdy[0]), 64'd1);
    chk("t2_fill_rel", 64'(fcnt[0]), 64'd1);
    rd(0, 12'd0, 64'hB0, 1'b0, 1, "t2_bank1_a0");
    rd(0, 12'd5, 64'hB5, 1'b0, 1, "t2_bank1_a5");

    // 3: commit and release together
    wr(0, 12'd0, 64'hC0, 1'b0);
    wr(0, 12'd5, 64'hC5, 1'b0);
    wv[0] = 1; wa[0] = 12'd1; wd[0] = 64'hC1; wl[0] = 1; rl[0] = 1;
    step();
    wv[0] = 0; wl[0] = 0; rl[0] = 0;
    chk("t3_fill", 64'(fcnt[0]), 64'd1);
    chk("t3_avail", 64'(ravl[0]), 64'd1);
    rd(0, 12'd0, 64'hC0, 1'b0, 1, "t3_new_a0");
    rd(0, 12'd1, 64'hC1, 1'b0, 1, "t3_new_a1");

    // 4: read issued with release targets the old bank
    wr(0, 12'd5, 64'hD5, 1'b1);
    chk("t4_fill2", 64'(fcnt[0]), 64'd2);
    rd(0, 12'd5, 64'hC5, 1'b1, 1, "t4_old_bank");
    chk("t4_fill1", 64'(fcnt[0]), 64'd1);
    rd(0, 12'd5, 64'hD5, 1'b0, 1, "t4_new_bank");
    release_bank(0);
    chk("t4_empty", 64'(ravl[0]), 64'd0);
    rq[0] = 1'b1; ra[0] = 12'd0;
    step();
    rq[0] = 1'b0;
    chk("t4_err1", 64'(err[0]), 64'd3);
    chk("t4_no_vld", 64'(rvld[0]), 64'd0);

    // 5: three-bank ring, seven rounds, RD_LAT=2
    for (int i = 0; i < 4; i++) wr(1, 12'(i * 3), pat(0, i), i == 3);
    for (int r = 0; r < 7; r++) begin
      if (r < 6)
        for (int i = 0; i < 4; i++) wr(1, 12'(i * 3), pat(r + 1, i), i == 3);
      chk("t5_fill", 64'(fcnt[1]), (r < 6) ? 64'd2 : 64'd1);
      for (int i = 0; i < 4; i++) rd(1, 12'(i * 3), pat(r, i), 1'b0, 2, "t5_rd");
      release_bank(1);
    end
    chk("t5_drained", 64'(fcnt[1]), 64'd0);
    chk("t5_err", 64'(err[1]), 64'd0);

    // 6: reset with reads in flight
    for (int i = 0; i < 4; i++) wr(1, 12'(i), pat(7, i), i == 3);
    rq[1] = 1'b1; ra[1] = 12'd0;
    step();
    ra[1] = 12'd1;
    step();
    rq[1] = 1'b0;
    chk("t6_first_vld", 64'(rvld[1]), 64'd1);
    chk("t6_first_data", rdat[1], pat(7, 0));
    rst_n = 1'b0;
    #1;
    chk("t6_vld_drop", 64'(rvld[1]), 64'd0);
    chk("t6_fill", 64'(fcnt[1]), 64'd0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t6_no_late_vld", 64'(rvld[1]), 64'd0);
      step();
    end
    for (int d = 0; d < 2; d++) begin
      chk("t6_err", 64'(err[d]), 64'd0);
      chk("t6_fill_cnt", 64'(fcnt[d]), 64'd0);
      chk("t6_rd_data", rdat[d], 64'd0);
      chk("t6_wr_ready", 64'(wrdy[d]), 64'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
